float_round_pack: RTL and testbench

Downstream stage of the sequential floating-point multiplier datapath.
- Accepts the raw product fields: sign, unbiased-sum exponent and the full 48-bit mantissa product.
- Normalizes them and rounds to nearest-even.
- Detects overflow and underflow, then packs the IEEE-754 single-precision result.
- Uses the same Start/DONE handshake and exposes its state and flags for the bench.

---
 rtl/float_round_pack_pkg.sv | 33 +++
 rtl/float_round_pack_rne_round.sv | 35 +++
 rtl/float_round_pack.sv | 172 +++++++++++++++++
 tb/tb_float_round_pack.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/float_round_pack_pkg.sv
// Shared floating-point definitions for the multiplier datapath.
// Holds:
//   - the IEEE-754 single-precision exponent constants;
//   - the infinity and quiet-NaN field patterns;
//   - the 3-bit state encoding used by every sequencer in the datapath, so
//     that state traces decode the same way everywhere;
//   - a small helper that packs sign/exponent/fraction into a 32-bit word.
package float_pkg;

    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;

    localparam logic [7:0]  INF_EXP   = 8'hFF;
    localparam logic [22:0] INF_FRAC  = 23'h000000;
    localparam logic [22:0] QNAN_FRAC = 23'h400000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NORM  = 3'd1,
        ST_ROUND = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [31:0] pack_fp(
        input logic        s,
        input logic [7:0]  e,
        input logic [22:0] f
    );
        return {s, e, f};
    endfunction

endpackage

// File: rtl/float_round_pack_rne_round.sv
// Combinational round-to-nearest-even of a 24-bit significand.
// Ports:
//   sig_in      - 24-bit significand (hidden bit at bit 23)
//   g           - guard bit, the first bit below the significand LSB
//   s           - sticky bit, the OR of every bit below the guard
//   sig_out     - rounded significand; reads 1.0 (24'h800000) on carry-out
//   carry_out   - the round-up overflowed the significand
//                 (the exponent must be bumped by one)
//   inexact_out - some discarded bit was nonzero
module rne_round (
    input  logic [23:0] sig_in,
    input  logic        g,
    input  logic        s,
    output logic [23:0] sig_out,
    output logic        carry_out,
    output logic        inexact_out
);

    logic        round_up_s;
    logic [24:0] sum_s;

    // Increment on more than half an ULP, or on an exact half when the LSB is odd.
    always_comb begin
        round_up_s  = g & (s | sig_in[0]);
        sum_s       = {1'b0, sig_in} + {24'd0, round_up_s};
        carry_out   = sum_s[24];
        inexact_out = g | s;
        if (sum_s[24]) begin
            sig_out = 24'h800000;
        end else begin
            sig_out = sum_s[23:0];
        end
    end

endmodule

// File: rtl/float_round_pack.sv
// Normalize, round (nearest-even) and pack stage of the floating-point
// multiplier.
// Ports:
//   CLK      - clock, rising edge
//   Reset    - asynchronous, active-low reset
//   Start    - request; sampled only in IDLE or DONE
//   Sign_in  - product sign
//   Exp_in   - signed biased exponent before normalization
//   Mant_in  - 48-bit significand product (bit 47 or bit 46 set)
//   Zero_in  - either operand is zero
//   Out      - packed single-precision result
//   DONE     - result valid
//   Over     - overflow; Out is signed infinity
//   Under    - underflow; Out is flushed to signed zero
//   Inexact  - a discarded bit was nonzero
//   Q        - current state
module float_round_pack
    import float_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 48
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Sign_in,
    input  logic [EXP_W-1:0]  Exp_in,
    input  logic [MANT_W-1:0] Mant_in,
    input  logic              Zero_in,
    output logic [31:0]       Out,
    output logic              DONE,
    output logic              Over,
    output logic              Under,
    output logic              Inexact,
    output logic [2:0]        Q
);

    localparam int MSB    = MANT_W - 1;
    localparam int SIG_LO = MANT_W - 25;
    localparam int G_BIT  = MANT_W - 26;

    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_NIL = EXP_W'(0);
    localparam logic signed [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX);

    state_e                   state_r;
    state_e                   state_next_s;
    logic                     sign_r;
    logic signed [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0]        mant_r;
    logic                     sticky_r;
    logic [23:0]              sig_r;
    logic [31:0]              out_r;
    logic                     done_r;
    logic                     over_r;
    logic                     under_r;
    logic                     inexact_r;

    logic                     sticky_all_s;
    logic [23:0]              rne_sig_s;
    logic                     rne_carry_s;
    logic                     rne_inexact_s;

    assign sticky_all_s = (|mant_r[G_BIT-1:0]) | sticky_r;

    rne_round u_rne (
        .sig_in      (mant_r[MANT_W-2:SIG_LO]),
        .g           (mant_r[G_BIT]),
        .s           (sticky_all_s),
        .sig_out     (rne_sig_s),
        .carry_out   (rne_carry_s),
        .inexact_out (rne_inexact_s)
    );

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: Start is honoured only while idle or holding a result.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_next_s = Zero_in ? ST_DONE : ST_NORM;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_NORM:  state_next_s = ST_ROUND;
            ST_ROUND: state_next_s = ST_CHECK;
            ST_CHECK: state_next_s = ST_DONE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: latch operands, normalize, round, then range-check and pack.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sign_r    <= 1'b0;
            exp_r     <= EXP_NIL;
            mant_r    <= {MANT_W{1'b0}};
            sticky_r  <= 1'b0;
            sig_r     <= 24'd0;
            out_r     <= 32'd0;
            done_r    <= 1'b0;
            over_r    <= 1'b0;
            under_r   <= 1'b0;
            inexact_r <= 1'b0;
        end else begin
            done_r <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        sign_r    <= Sign_in;
                        exp_r     <= $signed(Exp_in);
                        mant_r    <= Mant_in;
                        sticky_r  <= 1'b0;
                        over_r    <= 1'b0;
                        under_r   <= 1'b0;
                        inexact_r <= 1'b0;
                        if (Zero_in) begin
                            out_r <= pack_fp(Sign_in, 8'h00, 23'h000000);
                        end
                    end
                end
                ST_NORM: begin
                    // A product in [2,4) carries its leading one at the top bit.
                    if (mant_r[MSB]) begin
                        mant_r   <= {1'b0, mant_r[MSB:1]};
                        exp_r    <= exp_r + EXP_ONE;
                        sticky_r <= sticky_r | mant_r[0];
                    end
                end
                ST_ROUND: begin
                    sig_r     <= rne_sig_s;
                    exp_r     <= exp_r + (rne_carry_s ? EXP_ONE : EXP_NIL);
                    inexact_r <= rne_inexact_s;
                end
                ST_CHECK: begin
                    if (exp_r >= EXP_TOP) begin
                        out_r  <= pack_fp(sign_r, INF_EXP, INF_FRAC);
                        over_r <= 1'b1;
                    end else if ((exp_r <= EXP_NIL) || !sig_r[23]) begin
                        // A significand without its hidden bit has no normal
                        // encoding; it is flushed like any tiny result.
                        out_r   <= pack_fp(sign_r, 8'h00, 23'h000000);
                        under_r <= 1'b1;
                    end else begin
                        out_r <= pack_fp(sign_r, exp_r[7:0], sig_r[22:0]);
                    end
                end
                default: begin
                    out_r <= out_r;
                end
            endcase
        end
    end

    assign Out     = out_r;
    assign DONE    = done_r;
    assign Over    = over_r;
    assign Under   = under_r;
    assign Inexact = inexact_r;
    assign Q       = state_r;

endmodule

// File: tb/tb_float_round_pack.sv
// Self-checking bench for float_round_pack: directed cases followed by
// randomized operands compared against an arithmetic reference model.
module tb_float_round_pack;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Sign_in;
    logic [9:0]  Exp_in;
    logic [47:0] Mant_in;
    logic        Zero_in;
    logic [31:0] Out;
    logic        DONE;
    logic        Over;
    logic        Under;
    logic        Inexact;
    logic [2:0]  Q;

    int n_vec = 0;
    int n_mis = 0;

    float_round_pack #(.EXP_W(10), .MANT_W(48)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .Sign_in (Sign_in),
        .Exp_in  (Exp_in),
        .Mant_in (Mant_in),
        .Zero_in (Zero_in),
        .Out     (Out),
        .DONE    (DONE),
        .Over    (Over),
        .Under   (Under),
        .Inexact (Inexact),
        .Q       (Q)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: take the top 24 bits of the product as the significand and
    // compare the discarded remainder with half an ULP.
    // Returns {over, under, inexact, out}.
    function automatic logic [34:0] ref_model(input logic s, input logic [9:0] e,
                                              input logic [47:0] m, input logic z);
        longint unsigned mm, q, rem, half;
        int ee, sh;
        logic ov, un, ix;
        logic [31:0] o;
        if (z) return {3'b000, s, 31'd0};
        ee = $signed(e);
        sh = m[47] ? 24 : 23;
        if (m[47]) ee++;
        mm   = 64'(m);
        q    = mm >> sh;
        rem  = mm - (q << sh);
        half = 64'd1 << (sh - 1);
        ix   = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            ee++;
        end
        ov = (ee >= 255);
        un = !ov && (ee <= 0);
        if (ov)      o = {s, 8'hFF, 23'd0};
        else if (un) o = {s, 31'd0};
        else         o = {s, 8'(ee), 23'(q)};
        return {ov, un, ix, o};
    endfunction

    // One operation: Q must walk 1,2,3,4 (or jump to 4 for a zero operand),
    // then the result is compared with the model. With glitch set, a
    // conflicting Start is driven while in NORM and must be ignored.
    task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                          input logic [47:0] m, input logic z, input bit glitch);
        logic [34:0] r;
        r = ref_model(s, e, m, z);
        @(negedge CLK);
        Sign_in = s; Exp_in = e; Mant_in = m; Zero_in = z; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        if (!z) begin
            for (int st = 1; st <= 3; st++) begin
                chk({tag, "/q"}, 32'(Q), 32'(st));
                chk({tag, "/done"}, 32'(DONE), 32'd0);
                if (glitch && st == 1) begin
                    Start = 1'b1; Sign_in = ~s; Exp_in = 10'd200; Mant_in = ~m; Zero_in = 1'b1;
                end else begin
                    Start = 1'b0;
                end
                @(negedge CLK);
            end
            Start = 1'b0;
        end
        chk({tag, "/q_done"}, 32'(Q), 32'd4);
        chk({tag, "/done"}, 32'(DONE), 32'd1);
        chk({tag, "/out"}, Out, r[31:0]);
        chk({tag, "/over"}, 32'(Over), 32'(r[34]));
        chk({tag, "/under"}, 32'(Under), 32'(r[33]));
        if (!(r[34] || r[33])) chk({tag, "/inexact"}, 32'(Inexact), 32'(r[32]));
    endtask

    initial begin
        logic [47:0] m;
        logic [9:0]  e;
        logic        z;
        Reset = 1'b1; Start = 1'b0; Sign_in = 1'b0; Zero_in = 1'b0;
        Exp_in = 10'd0; Mant_in = 48'd0;
        #3 Reset = 1'b0;
        #4;
        chk("rst/q", 32'(Q), 32'd0);
        chk("rst/out", Out, 32'd0);
        chk("rst/done", 32'(DONE), 32'd0);
        chk("rst/flags", 32'({Over, Under, Inexact}), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        // Directed cases (also cross-checked against fixed expected words).
        run_op("exact", 1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b0);
        chk("exact/word", Out, 32'h40100000);
        run_op("tie_odd", 1'b0, 10'd127, 48'h400000C00000, 1'b0, 1'b0);
        chk("tie_odd/word", Out, 32'h3F800002);
        run_op("tie_even", 1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0);
        chk("tie_even/word", Out, 32'h3F800000);
        run_op("carry", 1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0);
        chk("carry/word", Out, 32'h40000000);
        run_op("over", 1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0);
        chk("over/word", Out, 32'h7F800000);
        run_op("under", 1'b0, 10'h3F6, 48'h400000000000, 1'b0, 1'b0);
        chk("under/word", Out, 32'h00000000);
        run_op("zero", 1'b1, 10'd127, 48'h400000000000, 1'b1, 1'b0);
        chk("zero/word", Out, 32'h80000000);
        run_op("glitch", 1'b0, 10'd127, 48'h900000000000, 1'b0, 1'b1);
        chk("glitch/word", Out, 32'h40100000);

        // Reset while in ROUND aborts the operation at once.
        @(negedge CLK);
        Sign_in = 1'b1; Exp_in = 10'd130; Mant_in = 48'h600000000000; Zero_in = 1'b0; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        chk("abort/q_pre", 32'(Q), 32'd2);
        Reset = 1'b0;
        #1;
        chk("abort/q", 32'(Q), 32'd0);
        chk("abort/out", Out, 32'd0);
        chk("abort/done", 32'(DONE), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        // Randomized operands; mostly in the normal range, some out of it.
        for (int i = 0; i < 40; i++) begin
            m = {16'($urandom), $urandom};
            if ($urandom_range(0, 1) == 1) m[47] = 1'b1;
            else m[47:46] = 2'b01;
            if ($urandom_range(0, 3) == 0) m[21:0] = 22'd0;
            if ($urandom_range(0, 9) < 7) e = 10'($urandom_range(1, 253));
            else e = 10'(int'($urandom_range(0, 506)) - 125);
            z = ($urandom_range(0, 15) == 0);
            run_op("rand", 1'($urandom), e, m, z, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
